acq_frame_scheduler: RTL and testbench
======================================

Name: acq_frame_scheduler

Overview:
Sequences acquisition frames for the concentrator's multiport sensor-capture memory.
- Each frame: clear the capture offsets, wait for all channels to finish (start-of-transfer), then supervise the DMA read-out until end-of-read.
- Checks read-out length and captures the per-channel CRC status.
- Includes watchdog timeouts for the collect and transfer phases.
- Sits between the host/DMA control registers and the multiport access memory; drives its power-on/clear and ok-status acknowledge inputs.

Parameters:
SENSORS, 8, number of sensor channels (width of ok_rx and ok_mask).
PACKET_BYTES, 16, bytes per sensor packet including CRC.
CRC_BYTES, 2, CRC bytes per packet (not read out).
TIMEOUT_CYCLES, 100000, watchdog limit per phase in clk cycles (must be >= 2).
Derived: EXP_BYTES = SENSORS*(PACKET_BYTES-CRC_BYTES); TW = $clog2(TIMEOUT_CYCLES); BW = $clog2(EXP_BYTES+2).

Ports:
clk  in  1  system clock, all logic on rising edge
pon_n  in  1  asynchronous active-low reset
enable  in  1  level; 1 = run frames back-to-back
err_clr  in  1  one-cycle pulse; clears sticky errors
sot  in  1  start-of-transfer from capture memory (all channels complete)
rd_en  in  1  memory read strobe (one byte per cycle when high)
eor  in  1  end-of-read from memory, qualified with the last rd_en
ok_rx  in  SENSORS  per-channel CRC-ok flags from capture memory
mem_clear  out  1  one-cycle clear pulse to capture memory offsets/CRC
eot_ok_rx  out  1  one-cycle acknowledge clearing memory ok flags
busy  out  1  high whenever state != IDLE
frame_done  out  1  one-cycle pulse per completed frame
frame_ok  out  1  last frame: all channels CRC-ok and length correct
ok_mask  out  SENSORS  ok_rx snapshot of last completed frame
frame_cnt  out  16  completed-frame counter, wraps 0xFFFF -> 0
timeout_err  out  1  sticky watchdog error
len_err  out  1  sticky read-out length error

Behaviour:
- Reset (pon_n=0, asynchronous): state=IDLE.
  - All outputs 0: ok_mask=0, frame_cnt=0, timer=0, byte_cnt=0, per-frame len flag=0.
- All outputs are registered (Moore); no combinational input-to-output path.
- IDLE: enable=1 -> ARM; else stay.
- ARM: mem_clear=1 for exactly this one cycle; timer<=0; byte_cnt<=0; frame len flag<=0; -> COLLECT.
- COLLECT: timer+1 per cycle.
  - sot=1 -> TRANSFER, timer<=0.
  - Else if timer==TIMEOUT_CYCLES-1 -> TOUT.
  - sot and expiry in the same cycle: sot wins.
- TRANSFER: timer cleared on every rd_en=1 cycle, else +1.
  - byte_cnt += rd_en, saturating at EXP_BYTES+1.
  - Length check: if byte_cnt+rd_en > EXP_BYTES, set frame len flag and len_err.
  - eor=1 (with rd_en=1): if byte_cnt+1 != EXP_BYTES, set frame len flag and len_err; -> REPORT.
  - eor=1 with rd_en=0 is treated as a length error (count not incremented); -> REPORT.
  - No eor and timer==TIMEOUT_CYCLES-1 -> TOUT. Expiry coincident with eor: eor wins.
- REPORT (one cycle):
  - eot_ok_rx=1; ok_mask<=ok_rx (sampled this cycle).
  - frame_ok <= &ok_rx & ~frame len flag.
  - frame_done=1; frame_cnt+1.
  - Next: ARM if enable, else IDLE.
- TOUT (one cycle): timeout_err<=1; frame_ok<=0; frame_cnt and ok_mask unchanged; mem_clear not asserted here. Next: ARM if enable, else IDLE.
- enable=0 mid-frame: current frame completes normally (REPORT or TOUT), then IDLE. Never aborts a transfer.
- err_clr=1 clears timeout_err and len_err.
  - A set event in the same cycle wins (flag stays 1).
  - err_clr does not affect frame_ok or ok_mask.
- rd_en or eor outside TRANSFER: ignored. sot outside COLLECT: ignored.
- Latency: ARM to COLLECT 1 cycle; eor to frame_done/eot_ok_rx 1 cycle; frame end to next mem_clear 1 cycle (back-to-back).

Test Plan:
- SENSORS=4, PACKET_BYTES=8, CRC_BYTES=2 (EXP_BYTES=24), TIMEOUT_CYCLES=64, enable=1. sot at cycle 10, 24 rd_en pulses, eor with the 24th, ok_rx=4'hF -> frame_done=1, eot_ok_rx=1 next cycle, frame_ok=1, ok_mask=4'hF, frame_cnt=1, mem_clear pulses one cycle later.
- Same frame with ok_rx=4'b1011 -> frame_ok=0, ok_mask=4'b1011, len_err=0, frame_cnt increments.
- eor with the 23rd rd_en -> len_err=1, frame_ok=0. Next frame correct -> frame_ok=1 and len_err still 1 until an err_clr pulse sets it to 0.
- No sot for 64 cycles after ARM -> TOUT, timeout_err=1, frame_cnt unchanged, mem_clear re-asserted 1 cycle later. sot exactly on the 64th cycle -> TRANSFER, no error.
- enable dropped at byte 10 of TRANSFER -> frame finishes at eor with frame_done=1, then busy=0 and no further mem_clear. pon_n low mid-TRANSFER -> all outputs 0 immediately, IDLE.

Source files
------------

// File: rtl/acq_frame_scheduler_if.sv
// Control/status bundle between the acquisition frame scheduler and the
// host/DMA registers plus the multiport capture memory.
interface acq_frame_scheduler_if #(
  parameter int SENSORS = 8
);
  logic               enable;
  logic               err_clr;
  logic               sot;
  logic               rd_en;
  logic               eor;
  logic [SENSORS-1:0] ok_rx;
  logic               mem_clear;
  logic               eot_ok_rx;
  logic               busy;
  logic               frame_done;
  logic               frame_ok;
  logic [SENSORS-1:0] ok_mask;
  logic [15:0]        frame_cnt;
  logic               timeout_err;
  logic               len_err;

  modport master (
    output enable, err_clr, sot, rd_en, eor, ok_rx,
    input  mem_clear, eot_ok_rx, busy, frame_done, frame_ok, ok_mask,
           frame_cnt, timeout_err, len_err
  );

  modport slave (
    input  enable, err_clr, sot, rd_en, eor, ok_rx,
    output mem_clear, eot_ok_rx, busy, frame_done, frame_ok, ok_mask,
           frame_cnt, timeout_err, len_err
  );
endinterface

// File: rtl/acq_frame_scheduler.sv
// Frame sequencer for the multiport capture memory: clear, collect until
// start-of-transfer, supervise DMA read-out, report CRC/length status.
module acq_frame_scheduler #(
  parameter int SENSORS        = 8,
  parameter int PACKET_BYTES   = 16,
  parameter int CRC_BYTES      = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                  clk,
  input  logic                  pon_n,
  acq_frame_scheduler_if.slave  bus
);
  localparam int EXP_BYTES = SENSORS * (PACKET_BYTES - CRC_BYTES);
  localparam int TW        = $clog2(TIMEOUT_CYCLES);
  localparam int BW        = $clog2(EXP_BYTES + 2);

  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW:0]   CNT_EXP = (BW+1)'(EXP_BYTES);
  localparam logic [BW:0]   CNT_SAT = (BW+1)'(EXP_BYTES + 1);

  typedef enum logic [2:0] {
    IDLE, ARM, COLLECT, TRANSFER, REPORT, TOUT
  } state_t;

  state_t        state;
  logic [TW-1:0] timer;
  logic [BW-1:0] byte_cnt;
  logic          len_flag;
  logic [BW:0]   cnt_next;

  // one bit wider than byte_cnt so the saturated count plus a strobe still compares correctly
  always_comb begin
    cnt_next = {1'b0, byte_cnt} + (BW+1)'(bus.rd_en);
  end

  always_ff @(posedge clk or negedge pon_n) begin
    if (!pon_n) begin
      state           <= IDLE;
      timer           <= '0;
      byte_cnt        <= '0;
      len_flag        <= 1'b0;
      bus.mem_clear   <= 1'b0;
      bus.eot_ok_rx   <= 1'b0;
      bus.busy        <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.frame_ok    <= 1'b0;
      bus.ok_mask     <= '0;
      bus.frame_cnt   <= '0;
      bus.timeout_err <= 1'b0;
      bus.len_err     <= 1'b0;
    end else begin
      bus.mem_clear  <= 1'b0;
      bus.eot_ok_rx  <= 1'b0;
      bus.frame_done <= 1'b0;

      // clear first so a set event later in this block takes precedence
      if (bus.err_clr) begin
        bus.timeout_err <= 1'b0;
        bus.len_err     <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.enable) begin
            state         <= ARM;
            bus.mem_clear <= 1'b1;
            bus.busy      <= 1'b1;
          end
        end

        ARM: begin
          timer    <= '0;
          byte_cnt <= '0;
          len_flag <= 1'b0;
          state    <= COLLECT;
        end

        COLLECT: begin
          if (bus.sot) begin
            state <= TRANSFER;
            timer <= '0;
          end else if (timer == T_LAST) begin
            state <= TOUT;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        TRANSFER: begin
          timer <= bus.rd_en ? '0 : timer + TW'(1);
          if (cnt_next <= CNT_SAT) byte_cnt <= cnt_next[BW-1:0];
          if (cnt_next > CNT_EXP) begin
            len_flag    <= 1'b1;
            bus.len_err <= 1'b1;
          end
          if (bus.eor) begin
            if (!bus.rd_en || cnt_next != CNT_EXP) begin
              len_flag    <= 1'b1;
              bus.len_err <= 1'b1;
            end
            state          <= REPORT;
            bus.frame_done <= 1'b1;
            bus.eot_ok_rx  <= 1'b1;
          end else if (timer == T_LAST) begin
            state <= TOUT;
          end
        end

        REPORT: begin
          bus.ok_mask   <= bus.ok_rx;
          bus.frame_ok  <= (&bus.ok_rx) & ~len_flag;
          bus.frame_cnt <= bus.frame_cnt + 16'd1;
          if (bus.enable) begin
            state         <= ARM;
            bus.mem_clear <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        TOUT: begin
          bus.timeout_err <= 1'b1;
          bus.frame_ok    <= 1'b0;
          if (bus.enable) begin
            state         <= ARM;
            bus.mem_clear <= 1'b1;
          end else begin
            state    <= IDLE;
            bus.busy <= 1'b0;
          end
        end

        default: begin
          state    <= IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_acq_frame_scheduler.sv
// Self-checking bench for acq_frame_scheduler: directed and randomized frames
// compared against a frame-level outcome model.
module tb_acq_frame_scheduler;
  localparam int S   = 4;
  localparam int PB  = 8;
  localparam int CB  = 2;
  localparam int TMO = 64;
  localparam int EXP = S * (PB - CB);

  logic clk = 1'b0;
  logic pon_n;

  acq_frame_scheduler_if #(.SENSORS(S)) bus ();

  acq_frame_scheduler #(
    .SENSORS(S), .PACKET_BYTES(PB), .CRC_BYTES(CB), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .pon_n(pon_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  // frame-level reference state
  int           m_cnt;
  logic [S-1:0] m_mask;
  bit           m_ok, m_len, m_tout;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_cnt = 0; m_mask = '0; m_ok = 0; m_len = 0; m_tout = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_outs"}, {bus.mem_clear, bus.eot_ok_rx, bus.busy, bus.frame_done,
                         bus.frame_ok, bus.timeout_err, bus.len_err}, 0);
    chk({tag, "_mask"}, 32'(bus.ok_mask), 0);
    chk({tag, "_cnt"}, 32'(bus.frame_cnt), 0);
  endtask

  task automatic wait_arm();
    int k = 0;
    while (!bus.mem_clear && k < 10) begin
      tick();
      k++;
    end
    chk("arm_wait", 32'(bus.mem_clear), 1);
  endtask

  task automatic noisy_wait(input int n);
    repeat (n) begin
      bus.rd_en = 1'($urandom);
      bus.eor   = 1'($urandom);
      tick();
    end
    bus.rd_en = 1'b0;
    bus.eor   = 1'b0;
  endtask

  // Entered with ARM visible; leaves with the state after the frame visible.
  // sot_dly = collect cycle carrying sot (0 = never), stall = no eor after bytes.
  task automatic run_frame(input int sot_dly, input int nbytes, input bit eor_rd,
                           input bit stall, input logic [S-1:0] okv,
                           input bit clr_collect, input bit clr_eor, input bit drop_en);
    int  cyc;
    bit  bad;
    bus.ok_rx = okv;
    chk("arm_clear", 32'(bus.mem_clear), 1);
    chk("arm_busy", 32'(bus.busy), 1);
    tick();
    cyc = 1;
    chk("clear_once", 32'(bus.mem_clear), 0);
    if (clr_collect) begin
      bus.err_clr = 1'b1;
      tick();
      bus.err_clr = 1'b0;
      cyc = 2;
      m_len = 0; m_tout = 0;
      chk("clr_tout", 32'(bus.timeout_err), 0);
      chk("clr_len", 32'(bus.len_err), 0);
    end
    if (sot_dly == 0) begin
      noisy_wait(TMO - cyc);
      chk("collect_pre_exp", 32'(bus.busy && !bus.frame_done), 1);
      tick();
      chk("tout_state", 32'({bus.busy, bus.frame_done, bus.eot_ok_rx}), 32'b100);
      m_tout = 1; m_ok = 0;
      tick();
    end else begin
      noisy_wait(sot_dly - cyc);
      bus.sot = 1'b1;
      tick();
      bus.sot = 1'b0;
      for (int i = 0; i < nbytes; i++) begin
        repeat ($urandom_range(0, 3)) tick();
        bus.rd_en = 1'b1;
        if (i == nbytes - 1 && eor_rd && !stall) begin
          bus.eor = 1'b1;
          bus.err_clr = clr_eor;
        end
        if (drop_en && i == 10) bus.enable = 1'b0;
        tick();
        bus.rd_en = 1'b0; bus.eor = 1'b0; bus.err_clr = 1'b0;
      end
      if (stall) begin
        repeat (TMO - 1) tick();
        chk("xfer_pre_exp", 32'(bus.busy && !bus.frame_done), 1);
        tick();
        chk("xfer_tout", 32'({bus.busy, bus.frame_done}), 32'b10);
        m_tout = 1; m_ok = 0;
        if (nbytes > EXP) m_len = 1;
        tick();
      end else begin
        if (!eor_rd) begin
          bus.eor = 1'b1;
          bus.err_clr = clr_eor;
          tick();
          bus.eor = 1'b0; bus.err_clr = 1'b0;
        end
        chk("frame_done", 32'(bus.frame_done), 1);
        chk("eot_ok_rx", 32'(bus.eot_ok_rx), 1);
        bad = !(eor_rd && nbytes == EXP);
        if (clr_eor) begin m_len = 0; m_tout = 0; end
        if (bad) m_len = 1;
        m_ok   = (&okv) && !bad;
        m_mask = okv;
        m_cnt  = (m_cnt + 1) & 32'hFFFF;
        tick();
      end
    end
    chk("done_pulse", 32'({bus.frame_done, bus.eot_ok_rx}), 0);
    chk("frame_cnt", 32'(bus.frame_cnt), 32'(m_cnt));
    chk("frame_ok", 32'(bus.frame_ok), 32'(m_ok));
    chk("ok_mask", 32'(bus.ok_mask), 32'(m_mask));
    chk("len_err", 32'(bus.len_err), 32'(m_len));
    chk("timeout_err", 32'(bus.timeout_err), 32'(m_tout));
    chk("next_clear", 32'(bus.mem_clear), 32'(bus.enable));
    chk("next_busy", 32'(bus.busy), 32'(bus.enable));
  endtask

  initial begin
    bit quiet;
    pon_n = 1'b0;
    bus.enable = 1'b0; bus.err_clr = 1'b0; bus.sot = 1'b0;
    bus.rd_en = 1'b0; bus.eor = 1'b0; bus.ok_rx = '0;
    model_reset();
    #23;
    chk_all_zero("reset");
    tick();
    pon_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy", 32'(bus.busy || bus.mem_clear), 0);
    bus.enable = 1'b1;
    wait_arm();

    // directed frames
    run_frame(10, EXP, 1, 0, 4'hF, 0, 0, 0);
    run_frame(10, EXP, 1, 0, 4'b1011, 0, 0, 0);
    run_frame(10, EXP - 1, 1, 0, 4'hF, 0, 0, 0);
    run_frame(10, EXP, 1, 0, 4'hF, 0, 0, 0);
    run_frame(5, EXP, 1, 0, 4'hF, 1, 0, 0);
    run_frame(0, 0, 0, 0, 4'hF, 0, 0, 0);
    run_frame(TMO, EXP, 1, 0, 4'hF, 1, 0, 0);
    run_frame(7, EXP + 2, 1, 0, 4'hF, 0, 0, 0);
    run_frame(7, EXP, 0, 0, 4'hF, 1, 0, 0);
    run_frame(7, 12, 1, 1, 4'hF, 1, 0, 0);
    run_frame(7, EXP + 1, 1, 0, 4'h7, 1, 1, 0);

    // randomized frames
    for (int f = 0; f < 25; f++) begin
      int sd, nb;
      sd = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(3, TMO));
      nb = ($urandom_range(0, 9) < 7) ? EXP : int'($urandom_range(EXP - 3, EXP + 3));
      run_frame(sd, nb, ($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 1) == 1) ? 4'hF : S'($urandom),
                ($urandom_range(0, 6) == 0), ($urandom_range(0, 6) == 0), 0);
    end

    // enable dropped mid-transfer: frame completes, then stays idle
    run_frame(6, EXP, 1, 0, 4'hF, 0, 0, 1);
    quiet = 1'b1;
    repeat (5) begin
      tick();
      if (bus.mem_clear || bus.busy) quiet = 1'b0;
    end
    chk("stay_idle", 32'(quiet), 1);

    // asynchronous reset mid-transfer
    bus.enable = 1'b1;
    wait_arm();
    repeat (4) tick();
    bus.sot = 1'b1;
    tick();
    bus.sot = 1'b0;
    bus.rd_en = 1'b1;
    repeat (5) tick();
    chk("mid_busy", 32'(bus.busy), 1);
    pon_n = 1'b0;
    #1;
    chk_all_zero("async_rst");
    bus.rd_en = 1'b0;
    model_reset();
    tick();
    pon_n = 1'b1;
    wait_arm();
    run_frame(10, EXP, 1, 0, 4'hF, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
    $fatal(1);
  end
endmodule
